// File: rtl/round_robin_distributor.sv
// Round-robin distributor: one input stream is spread over SIZE registered
// output buffers, and each word goes to the next available channel.
module round_robin_distributor #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_valid,
    input  logic [WIDTH-1:0]      write_data,
    output logic                  write_ready,
    output logic [SIZE-1:0]       read_valid,
    output logic [SIZE*WIDTH-1:0] read_data,
    input  logic [SIZE-1:0]       read_ready
);
    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(SIZE - 1);

    logic [SIZE-1:0]  vld_p1;
    logic [WIDTH-1:0] data_p1 [SIZE];
    logic [PTR_W-1:0] ptr_p1;

    logic [SIZE-1:0]  avail_p0;
    logic [PTR_W-1:0] sel_hi_p0;
    logic [PTR_W-1:0] sel_lo_p0;
    logic             hi_found_p0;
    logic [PTR_W-1:0] sel_p0;
    logic [PTR_W-1:0] ptr_next_p0;
    logic             take_p0;

    // Stage 0: availability and pointer-relative channel selection.
    // A full buffer whose consumer is ready this cycle counts as available.
    assign avail_p0    = ~vld_p1 | read_ready;
    assign write_ready = |avail_p0;
    assign take_p0     = write_valid & write_ready;

    // Downward scan: the last hit is the lowest index. sel_hi is the lowest
    // available channel at or above the pointer, sel_lo the lowest overall
    // (used when the search wraps past SIZE-1).
    always_comb begin
        sel_hi_p0   = '0;
        sel_lo_p0   = '0;
        hi_found_p0 = 1'b0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (avail_p0[i]) begin
                sel_lo_p0 = PTR_W'(i);
                if (PTR_W'(i) >= ptr_p1) begin
                    sel_hi_p0   = PTR_W'(i);
                    hi_found_p0 = 1'b1;
                end
            end
        end
        sel_p0      = hi_found_p0 ? sel_hi_p0 : sel_lo_p0;
        ptr_next_p0 = (sel_p0 == LAST) ? '0 : sel_p0 + PTR_W'(1);
    end

    // Stage 1: output buffers and priority pointer.
    // Data is cleared on reset as well so read_data reads zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= '0;
            ptr_p1 <= '0;
            for (int i = 0; i < SIZE; i++) begin
                data_p1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (take_p0 && (sel_p0 == PTR_W'(i))) begin
                    vld_p1[i]  <= 1'b1;
                    data_p1[i] <= write_data;
                end else if (read_ready[i]) begin
                    vld_p1[i] <= 1'b0;
                end
            end
            if (take_p0) begin
                ptr_p1 <= ptr_next_p0;
            end
        end
    end

    assign read_valid = vld_p1;

    always_comb begin
        read_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            read_data[i*WIDTH +: WIDTH] = data_p1[i];
        end
    end

endmodule

// File: tb/tb_round_robin_distributor.sv
// Bench for round_robin_distributor (SIZE=4, WIDTH=8): directed vector table,
// a skip-the-blocked-channel sequence and a random scoreboard run.
module tb_round_robin_distributor;
    localparam int W = 8;
    localparam int N = 4;

    logic           clock;
    logic           reset;
    logic           write_valid;
    logic [W-1:0]   write_data;
    logic           write_ready;
    logic [N-1:0]   read_valid;
    logic [N*W-1:0] read_data;
    logic [N-1:0]   read_ready;

    round_robin_distributor #(.WIDTH(W), .SIZE(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .write_valid(write_valid),
        .write_data (write_data),
        .write_ready(write_ready),
        .read_valid (read_valid),
        .read_data  (read_data),
        .read_ready (read_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic         wv;
        logic [7:0]   wd;
        logic [3:0]   rr;
        logic         exp_wr;
        logic [3:0]   exp_rv;
        logic [31:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] fifo [N][0:1023];
    int head [N];
    int tail [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic wv, input logic [7:0] wd,
                       input logic [3:0] rr, input logic ewr, input logic [3:0] erv,
                       input logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wd = wd; v.rr = rr;
        v.exp_wr = ewr; v.exp_rv = erv; v.exp_rd = erd;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1; write_valid = 1'b0; write_data = '0; read_ready = '0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        int ch_seq [6];
        int cnt [N];
        int n_acc;
        logic [3:0] mvld;
        int mptr;
        int sel;
        logic acc;

        reset = 1'b1; write_valid = 1'b0; write_data = '0; read_ready = '0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_rvalid", 32'(read_valid), 32'h0);
        chk("reset_rdata", read_data, 32'h0);
        chk("reset_wready", 32'(write_ready), 32'h1);
        @(posedge clock); #1;

        // rst wv  wd     rr    wr  rv     rd
        add(0, 1, 8'h10, 4'hF, 1, 4'h1, 32'h00000010);
        add(0, 1, 8'h11, 4'hF, 1, 4'h2, 32'h00001110);
        add(0, 1, 8'h12, 4'hF, 1, 4'h4, 32'h00121110);
        add(0, 1, 8'h13, 4'hF, 1, 4'h8, 32'h13121110);
        add(0, 1, 8'h14, 4'hF, 1, 4'h1, 32'h13121114);
        add(0, 1, 8'h15, 4'hF, 1, 4'h2, 32'h13121514);
        add(0, 1, 8'h16, 4'hF, 1, 4'h4, 32'h13161514);
        add(0, 1, 8'h17, 4'hF, 1, 4'h8, 32'h17161514);
        add(0, 0, 8'h00, 4'hF, 1, 4'h0, 32'h17161514);
        add(0, 1, 8'hA0, 4'h0, 1, 4'h1, 32'h171615A0);
        add(0, 1, 8'hA1, 4'h0, 1, 4'h3, 32'h1716A1A0);
        add(0, 1, 8'hA2, 4'h0, 1, 4'h7, 32'h17A2A1A0);
        add(0, 1, 8'hA3, 4'h0, 1, 4'hF, 32'hA3A2A1A0);
        add(0, 1, 8'hA4, 4'h0, 0, 4'hF, 32'hA3A2A1A0);
        add(0, 1, 8'hA4, 4'h0, 0, 4'hF, 32'hA3A2A1A0);
        add(0, 1, 8'hA4, 4'h1, 1, 4'hF, 32'hA3A2A1A4);
        add(0, 1, 8'hB2, 4'h4, 1, 4'hF, 32'hA3B2A1A4);
        add(0, 1, 8'hC3, 4'hF, 1, 4'h8, 32'hC3B2A1A4);
        add(0, 1, 8'hD0, 4'h0, 1, 4'h9, 32'hC3B2A1D0);
        add(0, 1, 8'hD1, 4'h0, 1, 4'hB, 32'hC3B2D1D0);
        add(1, 1, 8'hEE, 4'h4, 1, 4'h0, 32'h00000000);
        add(0, 1, 8'hE0, 4'h0, 1, 4'h1, 32'h000000E0);

        foreach (tbl[k]) begin
            reset = tbl[k].rst; write_valid = tbl[k].wv;
            write_data = tbl[k].wd; read_ready = tbl[k].rr;
            @(negedge clock);
            chk($sformatf("tbl%0d_wready", k), 32'(write_ready), 32'(tbl[k].exp_wr));
            @(posedge clock); #1;
            chk($sformatf("tbl%0d_rvalid", k), 32'(read_valid), 32'(tbl[k].exp_rv));
            chk($sformatf("tbl%0d_rdata", k), read_data, tbl[k].exp_rd);
        end
        reset = 1'b0;

        // Channel 1 stays full and blocked; the pointer must skip it.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            write_valid = 1'b1; write_data = 8'(8'h98 + k); read_ready = 4'h0;
            @(posedge clock); #1;
        end
        chk("skip_setup_rvalid", 32'(read_valid), 32'hF);
        ch_seq = '{0, 2, 3, 0, 2, 3};
        for (int k = 0; k < 6; k++) begin
            write_valid = 1'b1; write_data = 8'(8'h30 + k); read_ready = 4'b1101;
            @(negedge clock);
            chk($sformatf("skip%0d_wready", k), 32'(write_ready), 32'h1);
            @(posedge clock); #1;
            chk($sformatf("skip%0d_rvalid", k), 32'(read_valid),
                32'(4'b0010 | (4'b0001 << ch_seq[k])));
            chk($sformatf("skip%0d_data", k), 32'(read_data[ch_seq[k]*W +: W]), 32'(8'h30 + k));
            chk($sformatf("skip%0d_ch1", k), 32'(read_data[1*W +: W]), 32'h99);
        end

        // Random traffic against an independent scoreboard model.
        do_reset();
        mvld = '0; mptr = 0; n_acc = 0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; cnt[i] = 0; end
        for (int c = 0; c <= 1000; c++) begin
            write_valid = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            write_data  = 8'($urandom_range(0, 255));
            read_ready  = (c < 800) ? 4'($urandom_range(0, 15)) : 4'hF;
            @(negedge clock);
            chk("rnd_rvalid", 32'(read_valid), 32'(mvld));
            chk("rnd_wready", 32'(write_ready), 32'(|(~mvld | read_ready)));
            for (int i = 0; i < N; i++) begin
                if (read_valid[i] && read_ready[i]) begin
                    if (c > 800) cnt[i]++;
                    if (head[i] == tail[i]) begin
                        n_vec++; n_bad++;
                        $display("FAIL rnd_extra: channel %0d delivered %h, expected no word", i,
                                 read_data[i*W +: W]);
                    end else begin
                        chk($sformatf("rnd_ch%0d_data", i), 32'(read_data[i*W +: W]),
                            32'(fifo[i][head[i]]));
                        head[i]++;
                    end
                end
            end
            acc = write_valid && (|(~mvld | read_ready));
            sel = -1;
            for (int k = 0; k < N; k++) begin
                int cc;
                cc = (mptr + k) % N;
                if (sel < 0 && (!mvld[cc] || read_ready[cc])) sel = cc;
            end
            for (int i = 0; i < N; i++) begin
                if (acc && i == sel) mvld[i] = 1'b1;
                else if (read_ready[i]) mvld[i] = 1'b0;
            end
            if (acc) begin
                fifo[sel][tail[sel]] = write_data;
                tail[sel]++;
                mptr = (sel + 1) % N;
                if (c >= 800) n_acc++;
            end
            @(posedge clock); #1;
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rnd_ch%0d_left", i), 32'(tail[i] - head[i]), 32'h0);
            chk($sformatf("rnd_ch%0d_share", i), 32'(((4 * cnt[i] - n_acc) <= 4) &&
                                                   ((n_acc - 4 * cnt[i]) <= 4)), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
